// File: rtl/echo_receive_counter_pkg.sv
// ---------------------------------------------------------------------------
// echo_receive_counter_pkg
// Shared definitions for the echo receive path: controller state encoding,
// default widths and the TOF value reported when no echo was found.
// ---------------------------------------------------------------------------
package echo_receive_counter_pkg;

    localparam int SHAPE_W_DEF = 32;
    localparam int TOF_W_DEF   = 16;
    localparam int SCORE_W_DEF = 6;

    // TOF value meaning "no echo before the listen limit"; shared with the
    // transmit side so both ends agree on the marker.
    localparam logic [TOF_W_DEF-1:0] TOF_TIMEOUT = '1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LISTEN,
        DONE
    } rx_state_t;

endpackage

// File: rtl/echo_receive_counter_shape_match_scorer.sv
// ---------------------------------------------------------------------------
// shape_match_scorer
// Combinational correlator: counts the bit positions where the sampled echo
// window agrees with the expected pulse pattern (XNOR + popcount).
//   window  in  SHAPE_W  shifted echo samples, earliest sample in the MSB
//   pattern in  SHAPE_W  expected pulse shape
//   score   out SCORE_W  number of agreeing bit positions
// ---------------------------------------------------------------------------
module shape_match_scorer
    import echo_receive_counter_pkg::*;
#(
    parameter int SHAPE_W = SHAPE_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic [SHAPE_W-1:0] window,
    input  logic [SHAPE_W-1:0] pattern,
    output logic [SCORE_W-1:0] score
);

    logic [SHAPE_W-1:0] agree;

    always_comb begin
        agree = ~(window ^ pattern);
        score = '0;
        for (int unsigned i = 0; i < SHAPE_W; i++) begin
            score = score + SCORE_W'(agree[i]);
        end
    end

endmodule

// File: rtl/echo_receive_counter.sv
// ---------------------------------------------------------------------------
// echo_receive_counter
// Receive-side time-of-flight counter. Armed by the transmitter's pulse_sent,
// it blanks the receiver during ring-down, then shifts the echo comparator
// bit into a window and correlates it against the transmitted pulse shape.
// Reports TOF in clk cycles, or a timeout.
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   receiver_in_use   in   enable; deassertion aborts a listen
//   start_listen      in   one-cycle arm strobe
//   pulse_shape       in   expected echo pattern          (latched in IDLE)
//   match_threshold   in   minimum matching bit count     (latched in IDLE)
//   blank_cycles      in   blanking length                (latched in IDLE)
//   timeout_cycles    in   listen limit                   (latched in IDLE)
//   upload_new_config in   latch strobe for the four config inputs
//   echo_in           in   synchronised comparator output
//   echo_detected     out  one-cycle detection pulse
//   listen_complete   out  sticky: detection or timeout
//   timed_out         out  sticky: timeout
//   tof               out  captured TOF; all-ones on timeout
//   match_score       out  correlation score at the capture edge
// ---------------------------------------------------------------------------
module echo_receive_counter
    import echo_receive_counter_pkg::*;
#(
    parameter int SHAPE_W = SHAPE_W_DEF,
    parameter int TOF_W   = TOF_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               receiver_in_use,
    input  logic               start_listen,
    input  logic [SHAPE_W-1:0] pulse_shape,
    input  logic [SCORE_W-1:0] match_threshold,
    input  logic [TOF_W-1:0]   blank_cycles,
    input  logic [TOF_W-1:0]   timeout_cycles,
    input  logic               upload_new_config,
    input  logic               echo_in,
    output logic               echo_detected,
    output logic               listen_complete,
    output logic               timed_out,
    output logic [TOF_W-1:0]   tof,
    output logic [SCORE_W-1:0] match_score
);

    rx_state_t          state, state_d;
    logic [SHAPE_W-1:0] shape_cfg, shape_cfg_d;
    logic [SCORE_W-1:0] thr_cfg, thr_cfg_d;
    logic [TOF_W-1:0]   blank_cfg, blank_cfg_d;
    logic [TOF_W-1:0]   timeout_cfg, timeout_cfg_d;
    logic [TOF_W-1:0]   timer, timer_d;
    logic [SHAPE_W-1:0] sr, sr_d;
    // sample count never exceeds SHAPE_W, which fits in SCORE_W bits
    logic [SCORE_W-1:0] cnt, cnt_d;
    logic               echo_detected_d, listen_complete_d, timed_out_d;
    logic [TOF_W-1:0]   tof_d;
    logic [SCORE_W-1:0] match_score_d;

    logic [SHAPE_W-1:0] sr_shift;
    logic [SCORE_W-1:0] cnt_inc;
    logic [SCORE_W-1:0] score_next;
    logic [TOF_W-1:0]   timer_inc;
    logic               window_full, match, sample;

    assign sr_shift    = {sr[SHAPE_W-2:0], echo_in};
    assign cnt_inc     = (cnt == SCORE_W'(SHAPE_W)) ? cnt : cnt + SCORE_W'(1);
    assign timer_inc   = (&timer) ? timer : timer + TOF_W'(1);
    assign window_full = (cnt_inc == SCORE_W'(SHAPE_W));
    assign match       = window_full && (score_next >= thr_cfg);

    // Score is taken on the post-shift window so detection lands one cycle
    // after the completing sample.
    shape_match_scorer #(
        .SHAPE_W (SHAPE_W),
        .SCORE_W (SCORE_W)
    ) u_scorer (
        .window  (sr_shift),
        .pattern (shape_cfg),
        .score   (score_next)
    );

    always_comb begin
        state_d           = state;
        shape_cfg_d       = shape_cfg;
        thr_cfg_d         = thr_cfg;
        blank_cfg_d       = blank_cfg;
        timeout_cfg_d     = timeout_cfg;
        timer_d           = timer;
        sr_d              = sr;
        cnt_d             = cnt;
        echo_detected_d   = 1'b0;
        listen_complete_d = listen_complete;
        timed_out_d       = timed_out;
        tof_d             = tof;
        match_score_d     = match_score;
        sample            = 1'b0;

        unique case (state)
            IDLE: begin
                if (upload_new_config) begin
                    shape_cfg_d   = pulse_shape;
                    thr_cfg_d     = match_threshold;
                    blank_cfg_d   = blank_cycles;
                    timeout_cfg_d = timeout_cycles;
                end
                if (start_listen && receiver_in_use) begin
                    state_d           = BLANK;
                    timer_d           = '0;
                    sr_d              = '0;
                    cnt_d             = '0;
                    listen_complete_d = 1'b0;
                    timed_out_d       = 1'b0;
                    tof_d             = '0;
                    match_score_d     = '0;
                end
            end
            BLANK: begin
                if (!receiver_in_use) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                    sample  = (timer == blank_cfg);
                end
            end
            LISTEN: begin
                if (!receiver_in_use) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                    sample  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by the BLANK->LISTEN edge and every LISTEN edge. Using >= for
        // the timeout also covers a limit shorter than the blanking period,
        // which then fires on the first sampling edge.
        if (sample) begin
            state_d = LISTEN;
            sr_d    = sr_shift;
            cnt_d   = cnt_inc;
            if (match) begin
                state_d           = DONE;
                echo_detected_d   = 1'b1;
                listen_complete_d = 1'b1;
                tof_d             = timer;
                match_score_d     = score_next;
            end else if (timer >= timeout_cfg) begin
                state_d           = DONE;
                timed_out_d       = 1'b1;
                listen_complete_d = 1'b1;
                tof_d             = '1;
                match_score_d     = score_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            shape_cfg       <= '0;
            thr_cfg         <= '0;
            blank_cfg       <= '0;
            timeout_cfg     <= '0;
            timer           <= '0;
            sr              <= '0;
            cnt             <= '0;
            echo_detected   <= 1'b0;
            listen_complete <= 1'b0;
            timed_out       <= 1'b0;
            tof             <= '0;
            match_score     <= '0;
        end else begin
            state           <= state_d;
            shape_cfg       <= shape_cfg_d;
            thr_cfg         <= thr_cfg_d;
            blank_cfg       <= blank_cfg_d;
            timeout_cfg     <= timeout_cfg_d;
            timer           <= timer_d;
            sr              <= sr_d;
            cnt             <= cnt_d;
            echo_detected   <= echo_detected_d;
            listen_complete <= listen_complete_d;
            timed_out       <= timed_out_d;
            tof             <= tof_d;
            match_score     <= match_score_d;
        end
    end

endmodule

// File: tb/tb_echo_receive_counter.sv
// ---------------------------------------------------------------------------
// tb_echo_receive_counter
// Scoreboard bench: the driver computes each listen's outcome from the echo
// sequence with a window-correlation model and queues it; a monitor pops and
// compares whenever listen_complete rises.
// ---------------------------------------------------------------------------
module tb_echo_receive_counter;

    localparam int MAXT = 1024;
    localparam logic [31:0] S1 = 32'b01011011101111011111011111101011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        receiver_in_use = 1'b0;
    logic        start_listen = 1'b0;
    logic [31:0] pulse_shape = '0;
    logic [5:0]  match_threshold = '0;
    logic [15:0] blank_cycles = '0;
    logic [15:0] timeout_cycles = '0;
    logic        upload_new_config = 1'b0;
    logic        echo_in = 1'b0;
    logic        echo_detected, listen_complete, timed_out;
    logic [15:0] tof;
    logic [5:0]  match_score;

    echo_receive_counter #(.SHAPE_W(32), .TOF_W(16), .SCORE_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .receiver_in_use   (receiver_in_use),
        .start_listen      (start_listen),
        .pulse_shape       (pulse_shape),
        .match_threshold   (match_threshold),
        .blank_cycles      (blank_cycles),
        .timeout_cycles    (timeout_cycles),
        .upload_new_config (upload_new_config),
        .echo_in           (echo_in),
        .echo_detected     (echo_detected),
        .listen_complete   (listen_complete),
        .timed_out         (timed_out),
        .tof               (tof),
        .match_score       (match_score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit det;
        int t_end;
        int score;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    bit          echo_arr[MAXT];
    logic [31:0] cfg_shape = '0;
    int          cfg_thr = 0, cfg_blank = 0, cfg_timeout = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Reference: at timer value t (t >= blank) the window holds samples
    // t, t-1, ... in bits 0, 1, ...; samples before blank are zero.
    function automatic void model(output bit det, output int t_end, output int score);
        det = 0; t_end = MAXT - 1; score = 0;
        for (int t = cfg_blank; t < MAXT; t++) begin
            int sc = 0;
            for (int b = 0; b < 32; b++) begin
                bit s = 1'b0;
                if (t - b >= cfg_blank) s = echo_arr[t - b];
                if (s == cfg_shape[b]) sc++;
            end
            if ((t - cfg_blank + 1 >= 32) && (sc >= cfg_thr)) begin
                det = 1; t_end = t; score = sc; return;
            end
            if (t >= cfg_timeout) begin
                det = 0; t_end = t; score = sc; return;
            end
        end
    endfunction

    task automatic clear_echo();
        for (int i = 0; i < MAXT; i++) echo_arr[i] = 1'b0;
    endtask

    task automatic place_shape(input int start, input logic [31:0] sh);
        for (int j = 0; j < 32; j++) echo_arr[start + j] = sh[31 - j];
    endtask

    task automatic upload(input logic [31:0] sh, input int thr, input int blank, input int tmo);
        @(negedge clk);
        pulse_shape       = sh;
        match_threshold   = 6'(thr);
        blank_cycles      = 16'(blank);
        timeout_cycles    = 16'(tmo);
        upload_new_config = 1'b1;
        @(negedge clk);
        upload_new_config = 1'b0;
        cfg_shape = sh; cfg_thr = thr; cfg_blank = blank; cfg_timeout = tmo;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_det"}, echo_detected, 0);
        chk({tag, "_lc"}, listen_complete, 0);
        chk({tag, "_to"}, timed_out, 0);
        chk({tag, "_tof"}, tof, 0);
        chk({tag, "_score"}, match_score, 0);
    endtask

    // abort_at/start_at/upload_at: timer value at which to drop
    // receiver_in_use, re-strobe start_listen, or attempt a config upload
    // (negative disables).
    task automatic run_txn(input int abort_at, input int start_at, input int upload_at);
        bit det; int t_end; int sc; int last; bit aborted;
        exp_t e;
        model(det, t_end, sc);
        aborted = (abort_at >= 0) && (abort_at <= t_end);
        @(negedge clk);
        receiver_in_use = 1'b1; start_listen = 1'b1; echo_in = 1'b0;
        @(negedge clk);
        start_listen = 1'b0;
        if (!aborted) begin
            e.det = det; e.t_end = t_end; e.score = sc; e.cyc = cyc + 1 + t_end;
            exp_q.push_back(e);
        end
        last = aborted ? abort_at : t_end + 2;
        for (int k = 0; k <= last; k++) begin
            echo_in = echo_arr[k];
            start_listen = (k == start_at);
            if (k == abort_at) receiver_in_use = 1'b0;
            if (k == upload_at) begin
                pulse_shape = ~cfg_shape; match_threshold = '0;
                blank_cycles = 16'd3; timeout_cycles = 16'd2;
                upload_new_config = 1'b1;
            end
            @(negedge clk);
            upload_new_config = 1'b0; start_listen = 1'b0;
        end
        if (aborted) begin
            chk_idle_outputs("abort");
            receiver_in_use = 1'b1;
        end
    endtask

    // Monitor
    initial begin
        bit prev_lc = 0;
        bit pend = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_lc = 0; pend = 0;
            end else begin
                if (pend) begin
                    chk("det_pulse_len", echo_detected, 0);
                    pend = 0;
                end
                if (listen_complete && !prev_lc) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_complete", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("complete_cycle", cyc, e.cyc);
                        chk("echo_detected", echo_detected, e.det);
                        chk("timed_out", timed_out, !e.det);
                        chk("tof", tof, e.det ? e.t_end : 16'hFFFF);
                        chk("match_score", match_score, e.score);
                        pend = 1;
                    end
                end
                prev_lc = listen_complete;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        receiver_in_use = 1'b1;

        // 1: exact echo
        upload(S1, 32, 10, 500);
        clear_echo(); place_shape(50, S1);
        run_txn(-1, -1, -1);

        // 2: corrupted echo
        upload(S1, 30, 10, 500);
        echo_arr[55] = ~echo_arr[55]; echo_arr[70] = ~echo_arr[70];
        run_txn(-1, -1, -1);
        echo_arr[77] = ~echo_arr[77];
        run_txn(-1, -1, -1);

        // 3: blanking hides an early echo; zero blank samples immediately
        upload(S1, 32, 100, 300);
        clear_echo(); place_shape(20, S1);
        run_txn(-1, -1, -1);
        upload(S1, 32, 0, 300);
        clear_echo(); place_shape(0, S1);
        run_txn(-1, -1, -1);

        // 4: match on the timeout edge; zero threshold
        upload(S1, 32, 10, 81);
        clear_echo(); place_shape(50, S1);
        run_txn(-1, -1, -1);
        upload(S1, 0, 10, 500);
        clear_echo();
        run_txn(-1, -1, -1);

        // 5: upload and start during LISTEN ignored; abort then re-arm
        upload(S1, 32, 10, 500);
        clear_echo(); place_shape(50, S1);
        run_txn(-1, 70, 60);
        run_txn(-1, -1, -1);
        run_txn(40, -1, -1);
        run_txn(-1, -1, -1);
        chk("sticky_lc", listen_complete, 1);

        // 6: async reset clears sticky outputs between edges, and config
        @(posedge clk); #3; rst = 1'b0; #1;
        chk_idle_outputs("rst_async");
        @(negedge clk); rst = 1'b1;
        cfg_shape = '0; cfg_thr = 0; cfg_blank = 0; cfg_timeout = 0;
        clear_echo();
        run_txn(-1, -1, -1);
        upload(S1, 32, 10, 500);
        clear_echo(); place_shape(50, S1);
        @(negedge clk); start_listen = 1'b1;
        @(negedge clk); start_listen = 1'b0;
        repeat (40) @(negedge clk);
        @(posedge clk); #3; rst = 1'b0; #1;
        chk_idle_outputs("rst_listen");
        @(negedge clk); rst = 1'b1;
        upload(S1, 32, 10, 500);
        run_txn(-1, -1, -1);

        // random configurations and noisy/corrupted echoes
        for (int n = 0; n < 40; n++) begin
            logic [31:0] sh;
            int blank, tmo, thr, pos, nflip, noisy;
            sh    = $urandom;
            blank = $urandom_range(0, 40);
            thr   = $urandom_range(20, 33);
            tmo   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, blank)
                                                : blank + $urandom_range(20, 140);
            upload(sh, thr, blank, tmo);
            noisy = $urandom_range(0, 1);
            for (int i = 0; i < MAXT; i++)
                echo_arr[i] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            pos = $urandom_range(0, blank + 80);
            place_shape(pos, sh);
            nflip = $urandom_range(0, 3);
            for (int f = 0; f < nflip; f++) begin
                int p = pos + $urandom_range(0, 31);
                echo_arr[p] = ~echo_arr[p];
            end
            run_txn(-1, -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/echo_receive_counter.md
Name: echo_receive_counter

Overview:
Receive-side counterpart to Transmit_counter. Armed by the transmitter's pulse_sent. Blanks the receiver during ring-down, then shifts the digitised echo comparator bit into a window and correlates it against the same pulse_shape word the transmitter sent. Reports time-of-flight (TOF) in clk cycles, or a timeout, to the acquisition controller.

Parameters:
SHAPE_W, 32, pulse_shape / correlation window width in bits
TOF_W, 16, width of the TOF timer, blank and timeout fields
SCORE_W, 6, width of the match score and threshold; must satisfy 2^SCORE_W > SHAPE_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
receiver_in_use  in  1  enable; deassertion aborts any operation
start_listen  in  1  one-cycle arm strobe, driven by the transmitter's pulse_sent
pulse_shape  in  SHAPE_W  expected echo pattern
match_threshold  in  SCORE_W  minimum number of matching bits
blank_cycles  in  TOF_W  receiver blanking length
timeout_cycles  in  TOF_W  listen limit
upload_new_config  in  1  latches pulse_shape, threshold, blank and timeout
echo_in  in  1  comparator output, already synchronised upstream
echo_detected  out  1  one-cycle pulse on detection
listen_complete  out  1  sticky; set on detection or timeout
timed_out  out  1  sticky; set on timeout
tof  out  TOF_W  captured TOF; all-ones on timeout
match_score  out  SCORE_W  score at the capture edge

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output 0; config registers 0; timer 0; shift register 0; sample count 0.
- Config latch: upload_new_config=1 at an edge while in IDLE copies all four config inputs. It is ignored in any other state.
- States: IDLE, BLANK, LISTEN, DONE.
- IDLE -> BLANK: at an edge where start_listen=1 and receiver_in_use=1.
  - timer<=0, shift register<=0, sample count<=0.
  - listen_complete, timed_out, tof and match_score are cleared.
- start_listen outside IDLE is ignored.
- Timer: increments by 1 at every edge in BLANK or LISTEN. It saturates at all-ones.
- BLANK -> LISTEN: at the edge where timer==blank_cycles. That same edge takes the first sample, so blank_cycles=0 samples at the first edge after arming.
- Sampling: at each LISTEN edge, and at the BLANK->LISTEN edge:
  - sr <= {sr[SHAPE_W-2:0], echo_in}, so the earliest sample lands in the MSB.
  - sample count increments, saturating at SHAPE_W.
- Score: score_next = popcount(~(sr_next ^ pulse_shape_cfg)), computed on the post-shift value.
- Match: sample count (post-increment) == SHAPE_W and score_next >= match_threshold.
- On match:
  - state -> DONE.
  - echo_detected=1 for exactly the next cycle.
  - tof <= timer value before the increment, i.e. the timer value of the completing sample.
  - match_score <= score_next; listen_complete <= 1.
- Timeout: in LISTEN, if timer==timeout_cycles at an edge and there is no match at that edge:
  - state -> DONE.
  - timed_out <= 1, listen_complete <= 1.
  - tof <= all-ones, match_score <= score_next.
- Simultaneous match and timeout at one edge: the match wins.
- timeout_cycles < blank_cycles: timeout fires at the BLANK->LISTEN edge unless that edge matches.
- Thresholds: match_threshold=0 matches as soon as the window is full. A threshold > SHAPE_W never matches.
- DONE -> IDLE at the next edge. The sticky outputs hold until the next accepted start_listen or reset.
- receiver_in_use=0 at any edge in BLANK or LISTEN: -> IDLE. No outputs change and listen_complete stays 0.
- The score path is combinational within one cycle. No pipelining is allowed, because the one-cycle detection latency is a fixed requirement.

Decomposition:
- Shared package: state enum (IDLE, BLANK, LISTEN, DONE), SHAPE_W, TOF_W and SCORE_W defaults. The same package holds the TOF all-ones timeout marker, which the transmit side also uses.
- Sub-module shape_match_scorer: combinational XNOR plus popcount of window vs pattern.
  - Inputs: window and pattern, SHAPE_W each.
  - Output: score, SCORE_W.

Test Plan:
1. Exact echo. Config: shape=32'b01011011101111011111011111101011, threshold=32, blank=10, timeout=500. Action: arm, then drive shape MSB-first on echo_in for timer 50..81 -> echo_detected one cycle after timer-81 edge, tof=81, match_score=32, timed_out=0.
2. Corrupted echo, threshold 30. Two bits flipped -> detect with match_score=30. Three bits flipped (echo_in 0 otherwise) -> timed_out=1, tof=16'hFFFF, listen_complete=1.
3. Blanking. Blank=100: exact pattern sent over timer 20..51, then echo_in=0 -> no detection; timeout=300 fires at timer 300. Blank=0 -> first sample at the first edge after arming, tof=31 for a pattern driven immediately.
4. Boundary cases:
   - Pattern completing exactly at timer==timeout_cycles=81 -> detection wins, tof=81, timed_out=0.
   - Threshold=0 -> detect at tof=blank+31.
5. Control misuse:
   - upload_new_config during LISTEN -> config unchanged.
   - start_listen during LISTEN -> ignored.
   - receiver_in_use dropped at timer 40 -> IDLE with all outputs 0. A re-arm then works normally.
6. Reset. rst=0 mid-LISTEN (asynchronous, between edges) -> all outputs 0 immediately. After release, start_listen with the previous config uploaded again reproduces scenario 1.
